unified_buffer_replay: RTL and testbench

// - Multi-lane unified buffer: LANES x WIDTH-bit entries written by the activation pipeline, read by systolic feeder.
// - Adds replay: consumer marks a read position and rewinds to it to reuse a tile without re-writing.
// - Adds flush, almost-full/almost-empty thresholds and a sticky protocol-error flag.

---
 rtl/ub_pkg.sv | 22 ++
 rtl/ub_storage.sv | 29 ++
 rtl/unified_buffer_replay.sv | 133 +++++++++++++
 tb/tb_unified_buffer_replay.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
// Shared types and pointer helpers for the unified buffer with replay.
package ub_pkg;

  // Default geometry; the top-level parameters may override these.
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_LANES  = 4;
  // Wide enough for any supported pointer; callers truncate the result.
  localparam int unsigned PTR_CALC_W = 16;

  // One buffer entry at the default geometry; lane 0 occupies the low bits.
  typedef logic [DEF_LANES*DEF_WIDTH-1:0] entry_t;

  // Modular distance a - b. Truncating the result to the pointer width
  // gives the correct wrap-around distance.
  function automatic logic [PTR_CALC_W-1:0] ptr_dist(
    input logic [PTR_CALC_W-1:0] a,
    input logic [PTR_CALC_W-1:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/ub_storage.sv
// Entry storage: one write port (synchronous), one read port (asynchronous).
module ub_storage
  import ub_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ENTRY_W = 32,
  parameter int ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  // Contents are not reset. The read port is only meaningful while entries are live.
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  // Write the accepted entry at the write index.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/unified_buffer_replay.sv
// Multi-lane unified buffer with mark/rewind replay, flush and thresholds.
// The pointers carry one extra wrap bit, so full and empty can be told apart.
module unified_buffer_replay
  import ub_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int LANES    = 4,
  parameter  int DEPTH    = 64,
  parameter  int AF_LEVEL = 56,
  parameter  int AE_LEVEL = 4,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  input  logic [LANES*WIDTH-1:0]   wr_data,
  output logic                     wr_ready,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [LANES*WIDTH-1:0]   rd_data,
  input  logic                     rd_mark,
  input  logic                     rd_rewind,
  input  logic                     rd_release,
  output logic                     mark_active,
  output logic [ADDR_W:0]          count,
  output logic [ADDR_W:0]          held,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     proto_err
);

  localparam int PTR_W = ADDR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("unified_buffer_replay: DEPTH must be a power of two and >= 2");
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_mark_ptr;
  logic             r_mark_active;
  logic             r_proto_err;

  logic [PTR_W-1:0] w_base;
  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_held;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic             w_full;
  logic             w_empty;
  logic             w_do_wr;
  logic             w_do_rd;

  // Entries behind the mark stay occupied until the replay point is released.
  assign w_base  = r_mark_active ? r_mark_ptr : r_rd_ptr;
  assign w_held  = PTR_W'(ptr_dist(PTR_CALC_W'(r_wr_ptr), PTR_CALC_W'(w_base)));
  assign w_count = PTR_W'(ptr_dist(PTR_CALC_W'(r_wr_ptr), PTR_CALC_W'(r_rd_ptr)));
  assign w_full  = (w_held == PTR_W'(DEPTH));
  assign w_empty = (w_count == '0);

  assign wr_ready = ~w_full & ~flush;
  assign rd_valid = ~w_empty & ~flush & ~rd_rewind;
  assign w_do_wr  = wr_valid & wr_ready;
  assign w_do_rd  = rd_ready & rd_valid;

  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_do_rd);

  assign count        = w_count;
  assign held         = w_held;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_held >= PTR_W'(AF_LEVEL));
  assign almost_empty = (w_count <= PTR_W'(AE_LEVEL));
  assign mark_active  = r_mark_active;
  assign proto_err    = r_proto_err;

  // Pointer, mark and error bookkeeping. Priority: flush, then rewind, then mark/release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mark_ptr    <= '0;
      r_mark_active <= 1'b0;
      r_proto_err   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mark_ptr    <= '0;
      r_mark_active <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (rd_rewind) begin
        // A rewind cycle never pops, because rd_valid is low during it.
        if (r_mark_active) begin
          r_rd_ptr <= r_mark_ptr;
        end else begin
          r_proto_err <= 1'b1;
        end
      end else begin
        r_rd_ptr <= w_rd_ptr_next;
        // A mark in the same cycle as a release wins and re-marks.
        if (rd_mark) begin
          r_mark_ptr    <= w_rd_ptr_next;
          r_mark_active <= 1'b1;
        end else if (rd_release) begin
          r_mark_active <= 1'b0;
        end
      end
      // A consumer pop with nothing valid is a protocol violation.
      if (rd_ready && !rd_valid) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  ub_storage #(
    .DEPTH   (DEPTH),
    .ENTRY_W (LANES * WIDTH),
    .ADDR_W  (ADDR_W)
  ) u_storage (
    .clk       (clk),
    .i_wr_en   (w_do_wr),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (rd_data)
  );

endmodule

// File: tb/tb_unified_buffer_replay.sv
// Scoreboard bench for unified_buffer_replay. Pops push the expected entry;
// a monitor on the falling edge compares every accepted pop.
module tb_unified_buffer_replay;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_mark;
  logic        rd_rewind;
  logic        rd_release;
  logic        mark_active;
  logic [6:0]  count;
  logic [6:0]  held;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  unified_buffer_replay #(
    .WIDTH(8), .LANES(4), .DEPTH(64), .AF_LEVEL(56), .AE_LEVEL(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_mark(rd_mark), .rd_rewind(rd_rewind), .rd_release(rd_release),
    .mark_active(mark_active), .count(count), .held(held),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .proto_err(proto_err)
  );

  // Entry k holds bytes 4k+1 .. 4k+4, lane 0 lowest: dat(0) = 0x04030201.
  function automatic logic [31:0] dat(input int k);
    logic [7:0] b;
    b = 8'(k * 4);
    return {b + 8'd4, b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accepted pops are compared in order against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && rd_ready && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", rd_data, 32'h0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_data", rd_data, e);
        $display("pop data=0x%08h expected=0x%08h", rd_data, e);
      end
    end
  end

  task automatic idle();
    flush = 0; wr_valid = 0; wr_data = '0; rd_ready = 0;
    rd_mark = 0; rd_rewind = 0; rd_release = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic write(input logic [31:0] d);
    wr_valid = 1; wr_data = d;
    step();
  endtask

  task automatic pop(input logic [31:0] e);
    rd_ready = 1;
    exp_q.push_back(e);
    #1 chk("pop_rd_valid", {31'd0, rd_valid}, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 0;
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_almost_empty", {31'd0, almost_empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_almost_full", {31'd0, almost_full}, 32'd0);
    chk("rst_count", {25'd0, count}, 32'd0);
    chk("rst_held", {25'd0, held}, 32'd0);
    chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
    chk("rst_mark", {31'd0, mark_active}, 32'd0);
    reset_n = 1;
    step();

    // Four writes, then drain in order.
    for (int k = 0; k < 4; k++) write(dat(k));
    chk("w4_count", {25'd0, count}, 32'd4);
    chk("w4_rd_data", rd_data, 32'h04030201);
    chk("w4_almost_empty", {31'd0, almost_empty}, 32'd1);
    write(dat(4));
    chk("w5_almost_empty", {31'd0, almost_empty}, 32'd0);
    for (int k = 0; k < 4; k++) pop(dat(k));
    chk("w5_count", {25'd0, count}, 32'd1);

    // Fill to 64 entries; an extra write is refused.
    for (int k = 5; k < 68; k++) write(dat(k));
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("fill_count", {25'd0, count}, 32'd64);
    chk("fill_almost_full", {31'd0, almost_full}, 32'd1);
    write(32'hDEADBEEF);
    chk("fill_extra_count", {25'd0, count}, 32'd64);
    pop(dat(4));
    chk("pop1_count", {25'd0, count}, 32'd63);
    chk("pop1_wr_ready", {31'd0, wr_ready}, 32'd1);
    write(dat(68));
    chk("refill_full", {31'd0, full}, 32'd1);

    // Mark on a full buffer, pop 10: held entries still block writes.
    rd_mark = 1; step();
    chk("mark_active", {31'd0, mark_active}, 32'd1);
    for (int k = 5; k < 15; k++) pop(dat(k));
    chk("mk_count", {25'd0, count}, 32'd54);
    chk("mk_held", {25'd0, held}, 32'd64);
    chk("mk_wr_ready", {31'd0, wr_ready}, 32'd0);
    write(32'hBADBAD00);
    chk("mk_blocked_count", {25'd0, count}, 32'd54);
    rd_release = 1; step();
    chk("rel_held", {25'd0, held}, 32'd54);
    chk("rel_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rel_almost_full", {31'd0, almost_full}, 32'd0);
    chk("rel_mark", {31'd0, mark_active}, 32'd0);
    for (int k = 15; k < 69; k++) pop(dat(k));
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Mark at the first entry, pop 3, rewind, then replay all four.
    for (int k = 100; k < 104; k++) write(dat(k));
    rd_mark = 1; step();
    for (int k = 100; k < 103; k++) pop(dat(k));
    chk("pre_rw_count", {25'd0, count}, 32'd1);
    rd_rewind = 1;
    #1 chk("rw_rd_valid", {31'd0, rd_valid}, 32'd0);
    step();
    chk("rw_count", {25'd0, count}, 32'd4);
    chk("rw_held", {25'd0, held}, 32'd4);
    chk("rw_rd_data", rd_data, dat(100));
    chk("rw_mark_kept", {31'd0, mark_active}, 32'd1);
    for (int k = 100; k < 104; k++) pop(dat(k));
    rd_release = 1; step();
    chk("rw_end_empty", {31'd0, empty}, 32'd1);
    chk("rw_end_proto", {31'd0, proto_err}, 32'd0);

    // Rewind without a mark: pointers stay put, error is sticky.
    write(dat(200)); write(dat(201));
    rd_rewind = 1; step();
    chk("nm_count", {25'd0, count}, 32'd2);
    chk("nm_rd_data", rd_data, dat(200));
    chk("nm_proto", {31'd0, proto_err}, 32'd1);
    step(); step();
    chk("nm_proto_sticky", {31'd0, proto_err}, 32'd1);
    pop(dat(200)); pop(dat(201));

    // Flush overrides a concurrent write, pop and mark.
    for (int k = 300; k < 303; k++) write(dat(k));
    rd_mark = 1; step();
    flush = 1; wr_valid = 1; wr_data = 32'h12345678; rd_ready = 1; rd_mark = 1;
    #1 chk("fl_wr_ready", {31'd0, wr_ready}, 32'd0);
    step();
    chk("fl_count", {25'd0, count}, 32'd0);
    chk("fl_held", {25'd0, held}, 32'd0);
    chk("fl_empty", {31'd0, empty}, 32'd1);
    chk("fl_mark", {31'd0, mark_active}, 32'd0);
    chk("fl_proto", {31'd0, proto_err}, 32'd1);

    // Asynchronous reset pulse mid-stream.
    write(dat(400)); write(dat(401));
    pop(dat(400));
    #1 reset_n = 0;
    #2 reset_n = 1;
    #1;
    chk("ar_count", {25'd0, count}, 32'd0);
    chk("ar_held", {25'd0, held}, 32'd0);
    chk("ar_empty", {31'd0, empty}, 32'd1);
    chk("ar_proto", {31'd0, proto_err}, 32'd0);
    chk("ar_wr_ready", {31'd0, wr_ready}, 32'd1);
    step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
